// File: rtl/logic_axi4_stream_watermark_monitor_pkg.sv
// Shared types for the watermark monitor: state codes and the event payload.
package logic_axi4_stream_watermark_monitor_pkg;

  localparam logic [1:0] STATE_NORMAL = 2'd0;
  localparam logic [1:0] STATE_LOW    = 2'd1;
  localparam logic [1:0] STATE_HIGH   = 2'd2;

  typedef enum logic [1:0] {
    NORMAL = STATE_NORMAL,
    LOW    = STATE_LOW,
    HIGH   = STATE_HIGH
  } state_t;

  // Level field is kept wide so the struct is independent of COUNTER_WIDTH;
  // the level is zero-extended into it.
  localparam int unsigned EVT_LEVEL_W = 32;

  typedef struct packed {
    logic [EVT_LEVEL_W-1:0] level;
    logic                   overflow;
    state_t                 old_state;
    state_t                 new_state;
  } event_t;

endpackage

// File: rtl/logic_axi4_stream_if.sv
// Minimal AXI4-Stream bundle with source (tx) and sink (rx) views.
interface logic_axi4_stream_if #(
  parameter int TDATA_BYTES = 1,
  parameter int TID_W       = 1,
  parameter int TDEST_W     = 1,
  parameter int TUSER_W     = 1
) ();

  logic                     tvalid;
  logic                     tready;
  logic [8*TDATA_BYTES-1:0] tdata;
  logic [TDATA_BYTES-1:0]   tkeep;
  logic [TDATA_BYTES-1:0]   tstrb;
  logic                     tlast;
  logic [TID_W-1:0]         tid;
  logic [TDEST_W-1:0]       tdest;
  logic [TUSER_W-1:0]       tuser;

  modport tx (output tvalid, tdata, tkeep, tstrb, tlast, tid, tdest, tuser, input tready);
  modport rx (input tvalid, tdata, tkeep, tstrb, tlast, tid, tdest, tuser, output tready);

endinterface

// File: rtl/logic_axi4_stream_watermark_compare.sv
// Combinational next-state classifier with saturated hysteresis thresholds.
module logic_axi4_stream_watermark_compare
  import logic_axi4_stream_watermark_monitor_pkg::*;
#(
  parameter int COUNTER_MAX   = 256,
  parameter int COUNTER_WIDTH = 8,
  parameter int HYSTERESIS    = 4
) (
  input  state_t                 cur_state,
  input  logic [COUNTER_WIDTH:0] level,
  input  logic [COUNTER_WIDTH:0] high_watermark,
  input  logic [COUNTER_WIDTH:0] low_watermark,
  output state_t                 next_state
);

  // One extra bit of headroom so low_watermark + HYSTERESIS cannot wrap.
  localparam int CW = COUNTER_WIDTH + 2;
  localparam logic [CW-1:0] HYST_C = CW'(HYSTERESIS);
  localparam logic [CW-1:0] MAX_C  = CW'(COUNTER_MAX);

  logic [CW-1:0] lvl_x, hw_x, lw_x, hw_exit, lw_sum, lw_exit;

  // Classify: HIGH beats LOW, then hysteresis decides exits to NORMAL.
  always_comb begin
    lvl_x   = CW'(level);
    hw_x    = CW'(high_watermark);
    lw_x    = CW'(low_watermark);
    hw_exit = (hw_x >= HYST_C) ? hw_x - HYST_C : '0;
    lw_sum  = lw_x + HYST_C;
    lw_exit = (lw_sum > MAX_C) ? MAX_C : lw_sum;
    next_state = NORMAL;
    if (lvl_x >= hw_x) begin
      next_state = HIGH;
    end else if (lvl_x <= lw_x) begin
      next_state = LOW;
    end else if (cur_state == HIGH) begin
      next_state = (lvl_x < hw_exit) ? NORMAL : HIGH;
    end else if (cur_state == LOW) begin
      next_state = (lvl_x > lw_exit) ? NORMAL : LOW;
    end
  end

endmodule

// File: rtl/logic_axi4_stream_watermark_monitor.sv
// Fill-level watermark monitor: classifies level samples, emits one event
// beat per state change, tracks peak level and sticky overflow.
//
// state  | meaning
// NORMAL | level between the watermarks (with hysteresis)
// LOW    | level at or below low_watermark, not yet above low + HYSTERESIS
// HIGH   | level at or above high_watermark, not yet below high - HYSTERESIS
module logic_axi4_stream_watermark_monitor
  import logic_axi4_stream_watermark_monitor_pkg::*;
#(
  parameter int COUNTER_MAX   = 256,
  parameter int COUNTER_WIDTH = (COUNTER_MAX >= 2) ? $clog2(COUNTER_MAX) : 1,
  parameter int TDATA_BYTES   = 8 * ((COUNTER_WIDTH + 7) / 8),
  parameter int HYSTERESIS    = 4
) (
  input  logic                   aclk,
  input  logic                   areset,
  logic_axi4_stream_if.rx        rx,
  logic_axi4_stream_if.tx        tx,
  input  logic [COUNTER_WIDTH:0] high_watermark,
  input  logic [COUNTER_WIDTH:0] low_watermark,
  input  logic                   clear_peak,
  output logic [1:0]             level_state,
  output logic [COUNTER_WIDTH:0] peak_level,
  output logic                   overflow_seen
);

  localparam int LW = COUNTER_WIDTH + 1;
  localparam logic [LW-1:0] LEVEL_MAX = LW'(COUNTER_MAX);

  state_t            state_q, state_d, state_nxt;
  logic [LW-1:0]     peak_q, peak_d, level;
  logic              ovf_q, ovf_d, sample_ovf, accept;
  logic              tvalid_q, tvalid_d;
  event_t            evt_q, evt_d;
  logic [8*TDATA_BYTES-1:0] tx_data;
  logic              unused_rx;

  assign rx.tready  = !areset && (!tvalid_q || tx.tready);
  assign accept     = rx.tvalid && rx.tready;
  assign sample_ovf = rx.tdata[COUNTER_WIDTH];
  // An overflowed sample reads as full scale regardless of its value field.
  assign level      = sample_ovf ? LEVEL_MAX : {1'b0, rx.tdata[COUNTER_WIDTH-1:0]};
  assign unused_rx  = ^{rx.tdata[8*TDATA_BYTES-1:LW], rx.tkeep, rx.tstrb,
                        rx.tlast, rx.tid, rx.tdest, rx.tuser};

  logic_axi4_stream_watermark_compare #(
    .COUNTER_MAX  (COUNTER_MAX),
    .COUNTER_WIDTH(COUNTER_WIDTH),
    .HYSTERESIS   (HYSTERESIS)
  ) u_compare (
    .cur_state     (state_q),
    .level         (level),
    .high_watermark(high_watermark),
    .low_watermark (low_watermark),
    .next_state    (state_nxt)
  );

  // Next-state for the FSM, peak/sticky tracking and the event holding register.
  always_comb begin
    state_d  = state_q;
    peak_d   = peak_q;
    ovf_d    = ovf_q;
    evt_d    = evt_q;
    tvalid_d = tvalid_q && !tx.tready;
    if (accept) begin
      state_d = state_nxt;
      if (state_nxt != state_q) begin
        tvalid_d        = 1'b1;
        evt_d.new_state = state_nxt;
        evt_d.old_state = state_q;
        evt_d.overflow  = sample_ovf;
        evt_d.level     = EVT_LEVEL_W'(level);
      end
    end
    if (clear_peak) begin
      peak_d = accept ? level : '0;
      ovf_d  = accept && sample_ovf;
    end else if (accept) begin
      peak_d = (level > peak_q) ? level : peak_q;
      ovf_d  = ovf_q || sample_ovf;
    end
  end

  // State, tracking and holding registers with synchronous reset.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q  <= NORMAL;
      peak_q   <= '0;
      ovf_q    <= 1'b0;
      tvalid_q <= 1'b0;
      evt_q    <= '0;
    end else begin
      state_q  <= state_d;
      peak_q   <= peak_d;
      ovf_q    <= ovf_d;
      tvalid_q <= tvalid_d;
      evt_q    <= evt_d;
    end
  end

  // Pack the held event into the tx beat; unused bits stay zero.
  always_comb begin
    tx_data                   = '0;
    tx_data[1:0]              = evt_q.new_state;
    tx_data[3:2]              = evt_q.old_state;
    tx_data[4]                = evt_q.overflow;
    tx_data[8 +: EVT_LEVEL_W] = evt_q.level;
  end

  assign tx.tvalid = tvalid_q;
  assign tx.tdata  = tx_data;
  assign tx.tlast  = 1'b1;
  assign tx.tkeep  = '1;
  assign tx.tstrb  = '1;
  assign tx.tid    = '0;
  assign tx.tdest  = '0;
  assign tx.tuser  = '0;

  assign level_state   = state_q;
  assign peak_level    = peak_q;
  assign overflow_seen = ovf_q;

endmodule

// File: tb/tb_logic_axi4_stream_watermark_monitor.sv
// Directed bench with an event scoreboard for the watermark monitor.
module tb_logic_axi4_stream_watermark_monitor;

  localparam int TB = 8;

  logic       aclk = 1'b0;
  logic       areset;
  logic [8:0] high_watermark, low_watermark, peak_level;
  logic       clear_peak, overflow_seen;
  logic [1:0] level_state;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  logic_axi4_stream_if #(.TDATA_BYTES(TB)) rx_if ();
  logic_axi4_stream_if #(.TDATA_BYTES(TB)) tx_if ();

  logic_axi4_stream_watermark_monitor dut (
    .aclk          (aclk),
    .areset        (areset),
    .rx            (rx_if),
    .tx            (tx_if),
    .high_watermark(high_watermark),
    .low_watermark (low_watermark),
    .clear_peak    (clear_peak),
    .level_state   (level_state),
    .peak_level    (peak_level),
    .overflow_seen (overflow_seen)
  );

  always #5 aclk = ~aclk;

  function automatic logic [63:0] mk_evt(input logic [1:0] nw, input logic [1:0] od,
                                          input logic ovf, input logic [8:0] lvl);
    logic [63:0] d;
    d = '0;
    d[1:0] = nw;
    d[3:2] = od;
    d[4] = ovf;
    d[16:8] = lvl;
    return d;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every tx handshake pops and compares one expected event.
  always @(negedge aclk) begin
    if (!areset && tx_if.tvalid && tx_if.tready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event actual=%0h required=none", tx_if.tdata);
      end else begin
        check("event_tdata", tx_if.tdata, exp_q.pop_front());
        check("event_sideband",
              {55'd0, tx_if.tlast, tx_if.tkeep},
              {55'd0, 1'b1, 8'hFF});
        check("event_sideband2",
              {tx_if.tstrb, tx_if.tid, tx_if.tdest, tx_if.tuser},
              {8'hFF, 3'b000});
      end
    end
  end

  task automatic send(input logic ovf, input logic [7:0] val, input logic clr,
                      input logic [1:0] exp_state);
    logic [63:0] d;
    int n;
    d = '0;
    d[8] = ovf;
    d[7:0] = val;
    rx_if.tdata = d;
    rx_if.tvalid = 1'b1;
    clear_peak = clr;
    n = 0;
    @(negedge aclk);
    while (!rx_if.tready && n < 50) begin
      n++;
      @(negedge aclk);
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual=stalled required=accepted level=%0d", val);
    end
    @(posedge aclk);
    #1;
    rx_if.tvalid = 1'b0;
    clear_peak = 1'b0;
    @(negedge aclk);
    check("level_state", {62'd0, level_state}, {62'd0, exp_state});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    areset = 1'b1;
    high_watermark = 9'd200;
    low_watermark = 9'd50;
    clear_peak = 1'b0;
    rx_if.tvalid = 1'b0;
    rx_if.tdata = '0;
    rx_if.tkeep = '1;
    rx_if.tstrb = '1;
    rx_if.tlast = 1'b1;
    rx_if.tid = '0;
    rx_if.tdest = '0;
    rx_if.tuser = '0;
    tx_if.tready = 1'b1;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check("reset_rx_tready", {63'd0, rx_if.tready}, 64'd0);
    check("reset_state", {62'd0, level_state}, 64'd0);
    check("reset_peak", {55'd0, peak_level}, 64'd0);
    check("reset_ovf", {63'd0, overflow_seen}, 64'd0);
    check("reset_tvalid", {63'd0, tx_if.tvalid}, 64'd0);
    @(posedge aclk);
    #1 areset = 1'b0;

    // 1: enter HIGH, hold in hysteresis band, exit to NORMAL
    send(1'b0, 8'd100, 1'b0, 2'd0);
    exp_q.push_back(mk_evt(2'd2, 2'd0, 1'b0, 9'd200));
    send(1'b0, 8'd200, 1'b0, 2'd2);
    send(1'b0, 8'd198, 1'b0, 2'd2);
    exp_q.push_back(mk_evt(2'd0, 2'd2, 1'b0, 9'd195));
    send(1'b0, 8'd195, 1'b0, 2'd0);

    // 2: LOW entry and hysteresis exit
    exp_q.push_back(mk_evt(2'd1, 2'd0, 1'b0, 9'd50));
    send(1'b0, 8'd50, 1'b0, 2'd1);
    send(1'b0, 8'd54, 1'b0, 2'd1);
    exp_q.push_back(mk_evt(2'd0, 2'd1, 1'b0, 9'd55));
    send(1'b0, 8'd55, 1'b0, 2'd0);
    check("peak_after_t2", {55'd0, peak_level}, 64'd200);

    // 3: backpressure holds the event and stalls rx
    @(posedge aclk);
    #1 tx_if.tready = 1'b0;
    exp_q.push_back(mk_evt(2'd2, 2'd0, 1'b0, 9'd210));
    send(1'b0, 8'd210, 1'b0, 2'd2);
    rx_if.tdata = 64'd40;
    rx_if.tvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      check("held_tvalid", {63'd0, tx_if.tvalid}, 64'd1);
      check("held_rx_tready", {63'd0, rx_if.tready}, 64'd0);
      check("held_tdata", tx_if.tdata, mk_evt(2'd2, 2'd0, 1'b0, 9'd210));
    end
    exp_q.push_back(mk_evt(2'd1, 2'd2, 1'b0, 9'd40));
    @(posedge aclk);
    #1 tx_if.tready = 1'b1;
    @(posedge aclk);
    #1 rx_if.tvalid = 1'b0;
    @(negedge aclk);
    check("state_after_release", {62'd0, level_state}, 64'd1);
    check("peak_after_t3", {55'd0, peak_level}, 64'd210);

    // 4: overflow sample at hw = COUNTER_MAX, then standalone clear
    high_watermark = 9'd256;
    exp_q.push_back(mk_evt(2'd2, 2'd1, 1'b1, 9'd256));
    send(1'b1, 8'd0, 1'b0, 2'd2);
    check("ovf_seen_set", {63'd0, overflow_seen}, 64'd1);
    check("peak_ovf", {55'd0, peak_level}, 64'd256);
    high_watermark = 9'd200;
    clear_peak = 1'b1;
    @(posedge aclk);
    #1 clear_peak = 1'b0;
    @(negedge aclk);
    check("peak_cleared", {55'd0, peak_level}, 64'd0);
    check("ovf_cleared", {63'd0, overflow_seen}, 64'd0);

    // watermark change alone emits nothing; level 0 with lw 0 counts as LOW
    low_watermark = 9'd0;
    @(negedge aclk);
    check("no_event_on_wm_change", {63'd0, tx_if.tvalid}, 64'd0);
    exp_q.push_back(mk_evt(2'd1, 2'd2, 1'b0, 9'd0));
    send(1'b0, 8'd0, 1'b0, 2'd1);
    low_watermark = 9'd50;
    exp_q.push_back(mk_evt(2'd0, 2'd1, 1'b0, 9'd100));
    send(1'b0, 8'd100, 1'b0, 2'd0);

    // 5: clear_peak coincident with an accepted sample
    exp_q.push_back(mk_evt(2'd2, 2'd0, 1'b0, 9'd230));
    send(1'b0, 8'd230, 1'b0, 2'd2);
    check("peak_230", {55'd0, peak_level}, 64'd230);
    exp_q.push_back(mk_evt(2'd0, 2'd2, 1'b0, 9'd120));
    send(1'b0, 8'd120, 1'b1, 2'd0);
    check("peak_clear_with_accept", {55'd0, peak_level}, 64'd120);

    // 6: reset drops a pending event
    @(posedge aclk);
    #1 tx_if.tready = 1'b0;
    send(1'b0, 8'd210, 1'b0, 2'd2);
    areset = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    check("rst_tvalid", {63'd0, tx_if.tvalid}, 64'd0);
    check("rst_state", {62'd0, level_state}, 64'd0);
    check("rst_peak", {55'd0, peak_level}, 64'd0);
    @(posedge aclk);
    #1;
    areset = 1'b0;
    tx_if.tready = 1'b1;
    repeat (6) @(posedge aclk);
    @(negedge aclk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
